ramb16_s4_s18_fifo_ctl: RTL and testbench

//  Single-clock width-converting FIFO controller that drives an adjacent RAMB16_S4_S18 instance.
//  - Write side: 4-bit nibble stream in (valid/ready), written through RAM port A (4096x4).
//  - Read side: 16-bit words out (valid/ready), read through RAM port B (1024x18).
//  - Sits between the nibble-serial front end and 16-bit consumers.

---
 rtl/ramb16_fifo_pkg.sv | 18 +
 rtl/ramb16_fifo_outbuf.sv | 57 +++++
 rtl/ramb16_s4_s18_fifo_ctl.sv | 138 +++++++++++++
 tb/tb_ramb16_s4_s18_fifo_ctl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramb16_fifo_pkg.sv
// ramb16_fifo_pkg
//   Shared widths and pointer types for the RAMB16_S4_S18 width-converting
//   FIFO controller (4-bit write side on RAM port A, 16-bit read side on port B).
package ramb16_fifo_pkg;

   localparam int unsigned NIB_AW = 12;   // port A address width (4096 x 4)
   localparam int unsigned WRD_AW = 10;   // port B address width (1024 x 16)
   localparam int unsigned NIB_PW = 13;   // nibble pointer, one wrap bit above NIB_AW
   localparam int unsigned WRD_PW = 11;   // word pointer, one wrap bit above WRD_AW
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned WRD_W  = 16;

   localparam int unsigned NIB_DEPTH = 1 << NIB_AW;

   typedef logic [NIB_PW-1:0] nib_ptr_t;
   typedef logic [WRD_PW-1:0] wrd_ptr_t;

endpackage

// File: rtl/ramb16_fifo_outbuf.sv
// ramb16_fifo_outbuf
//   Two-entry 16-bit output buffer between the RAM read port and the word
//   consumer. The head entry stays stable until popped.
// Ports
//   clk, rst_n      clock, synchronous active-low reset (clears data too)
//   flush           synchronous clear of occupancy (data left in place)
//   push/push_data  write one word (caller guarantees a free slot)
//   pop             remove head word (caller guarantees valid)
//   head, valid     head word and non-empty flag
//   count           occupancy 0..2
module ramb16_fifo_outbuf
   import ramb16_fifo_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WRD_W-1:0] push_data,
   input  logic             pop,
   output logic [WRD_W-1:0] head,
   output logic             valid,
   output logic [1:0]       count
);

   logic [WRD_W-1:0] slot [2];
   logic             wr_idx;
   logic             rd_idx;
   logic [1:0]       cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_idx  <= 1'b0;
         rd_idx  <= 1'b0;
         cnt     <= '0;
      end else if (flush) begin
         wr_idx  <= 1'b0;
         rd_idx  <= 1'b0;
         cnt     <= '0;
      end else begin
         if (push) begin
            slot[wr_idx] <= push_data;
            wr_idx       <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head  = slot[rd_idx];
   assign valid = (cnt != '0);
   assign count = cnt;

endmodule

// File: rtl/ramb16_s4_s18_fifo_ctl.sv
// ramb16_s4_s18_fifo_ctl
//   Single-clock FIFO controller driving an adjacent RAMB16_S4_S18: nibbles
//   in through port A (4096x4), 16-bit words out through port B (1024x16).
//   The first-written nibble of a word lands in M_DATA[3:0].
// Ports
//   CLK, RST_N, FLUSH          clock, sync active-low reset, sync state clear
//   S_VALID/S_READY/S_DATA     nibble input handshake
//   M_VALID/M_READY/M_DATA     word output handshake
//   ADDRA/DIA/ENA/WEA/SSRA     RAM port A drive
//   ADDRB/ENB/WEB/SSRB/DIB/DIPB RAM port B drive (write side tied off)
//   DOB/DOPB                   RAM port B read data (parity ignored)
//   LEVEL/AFULL                nibble occupancy and almost-full flag, present
//                              only when RAMB16_S4S18_FIFO_LEVEL_EN is defined
module ramb16_s4_s18_fifo_ctl
   import ramb16_fifo_pkg::*;
`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
#(
   parameter int unsigned AFULL_LEVEL = 4032
)
`endif
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FLUSH,
   input  logic              S_VALID,
   output logic              S_READY,
   input  logic [NIB_W-1:0]  S_DATA,
   output logic              M_VALID,
   input  logic              M_READY,
   output logic [WRD_W-1:0]  M_DATA,
   output logic [NIB_AW-1:0] ADDRA,
   output logic [NIB_W-1:0]  DIA,
   output logic              ENA,
   output logic              WEA,
   output logic              SSRA,
   output logic [WRD_AW-1:0] ADDRB,
   output logic              ENB,
   output logic              WEB,
   output logic              SSRB,
   output logic [WRD_W-1:0]  DIB,
   output logic [1:0]        DIPB,
   input  logic [WRD_W-1:0]  DOB,
   input  logic [1:0]        DOPB
`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
  ,output logic [NIB_PW-1:0] LEVEL,
   output logic              AFULL
`endif
);

   nib_ptr_t         wr_ptr;
   wrd_ptr_t         rd_ptr;
   logic             inflight;
   nib_ptr_t         nib_cnt;
   wrd_ptr_t         words_avail;
   logic             wr_acc;
   logic             issue;
   logic             pop;
   logic [2:0]       pending;
   logic [1:0]       buf_cnt;
   logic             buf_valid;
   logic [WRD_W-1:0] buf_head;
   logic             unused_dopb;

   // Nibbles still held in RAM; words already issued to the read port no longer count.
   assign nib_cnt     = wr_ptr - {rd_ptr, 2'b00};
   assign words_avail = wr_ptr[NIB_PW-1:2] - rd_ptr;
   assign S_READY     = (nib_cnt != nib_ptr_t'(NIB_DEPTH));

   // Reset and flush cycles drop the handshake, so the RAM is not written either.
   assign wr_acc = S_VALID & S_READY & RST_N & ~FLUSH;
   assign ENA    = wr_acc;
   assign WEA    = wr_acc;
   assign ADDRA  = wr_ptr[NIB_AW-1:0];
   assign DIA    = S_DATA;
   assign SSRA   = 1'b0;

   // A read may only be issued if its word still fits in the buffer once it returns.
   assign pop     = buf_valid & M_READY;
   assign pending = {2'b00, inflight} + {1'b0, buf_cnt} - {2'b00, pop};
   assign issue   = RST_N & ~FLUSH & (words_avail != '0) & (pending < 3'd2);

   assign ENB   = issue;
   assign ADDRB = rd_ptr[WRD_AW-1:0];
   assign WEB   = 1'b0;
   assign SSRB  = 1'b0;
   assign DIB   = '0;
   assign DIPB  = '0;

   assign unused_dopb = ^DOPB;

   always_ff @(posedge CLK) begin
      if (!RST_N || FLUSH) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + nib_ptr_t'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + wrd_ptr_t'(1);
         end
         inflight <= issue;
      end
   end

   ramb16_fifo_outbuf u_outbuf (
      .clk       (CLK),
      .rst_n     (RST_N),
      .flush     (FLUSH),
      .push      (inflight),
      .push_data (DOB),
      .pop       (pop),
      .head      (buf_head),
      .valid     (buf_valid),
      .count     (buf_cnt)
   );

   assign M_VALID = buf_valid;
   assign M_DATA  = buf_head;

`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
   nib_ptr_t nib_cnt_next;

   assign nib_cnt_next = (wr_ptr + nib_ptr_t'(wr_acc)) - {rd_ptr + wrd_ptr_t'(issue), 2'b00};

   always_ff @(posedge CLK) begin
      if (!RST_N || FLUSH) begin
         LEVEL <= '0;
         AFULL <= 1'b0;
      end else begin
         LEVEL <= nib_cnt_next;
         AFULL <= (32'(nib_cnt_next) >= AFULL_LEVEL);
      end
   end
`endif

endmodule

// File: tb/tb_ramb16_s4_s18_fifo_ctl.sv
// tb_ramb16_s4_s18_fifo_ctl
//   Directed and randomized bench for ramb16_s4_s18_fifo_ctl with a
//   behavioural RAMB16_S4_S18 model and a queue-based FIFO reference.
module tb_ramb16_s4_s18_fifo_ctl;

   logic        clk = 1'b0;
   logic        rst_n, flush, s_valid, m_ready;
   logic [3:0]  s_data;
   logic        s_ready, m_valid;
   logic [15:0] m_data;
   logic [11:0] addra;
   logic [3:0]  dia;
   logic        ena, wea, ssra, enb, web, ssrb;
   logic [9:0]  addrb;
   logic [15:0] dib, dob;
   logic [1:0]  dipb;
   logic [1:0]  dopb = 2'b00;
`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
   logic [12:0] level;
   logic        afull;
`endif

   always #5 clk = ~clk;

   ramb16_s4_s18_fifo_ctl dut (
      .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
      .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
      .ADDRA(addra), .DIA(dia), .ENA(ena), .WEA(wea), .SSRA(ssra),
      .ADDRB(addrb), .ENB(enb), .WEB(web), .SSRB(ssrb), .DIB(dib), .DIPB(dipb),
      .DOB(dob), .DOPB(dopb)
`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
     ,.LEVEL(level), .AFULL(afull)
`endif
   );

   // RAMB16_S4_S18: port B word k holds port A nibbles 4k..4k+3, lowest address in [3:0].
   logic [3:0] ram [4096];
   always @(posedge clk) begin
      if (ena && wea) ram[addra] <= dia;
      if (enb) dob <= {ram[{addrb, 2'd3}], ram[{addrb, 2'd2}], ram[{addrb, 2'd1}], ram[{addrb, 2'd0}]};
   end

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned pops  = 0;
   logic        s_acc, m_pop, stall_prev = 1'b0, rst_seen = 1'b0;
   logic        obs_enb, obs_mvalid, obs_sready;
   logic [15:0] obs_mdata, held;
   logic [3:0]  nibq [$];
   logic [15:0] wordq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs were driven after the previous edge; observe at
   // the falling edge, update the reference, then step past the rising edge.
   task automatic cyc();
      @(negedge clk);
      s_acc      = 1'b0;
      m_pop      = 1'b0;
      obs_enb    = enb;
      obs_mvalid = m_valid;
      obs_mdata  = m_data;
      obs_sready = s_ready;
      if (!rst_n) begin
         check("rst_wea", wea, 0);
         check("rst_enb", enb, 0);
      end
      if (rst_seen) begin
         check("rst_s_ready", s_ready, 1);
         check("rst_m_valid", m_valid, 0);
         check("rst_m_data", m_data, 0);
`ifdef RAMB16_S4S18_FIFO_LEVEL_EN
         check("rst_level", level, 0);
         check("rst_afull", afull, 0);
`endif
      end
      if (!rst_n || flush) begin
         nibq.delete();
         wordq.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, held);
         end
         if (m_valid && m_ready) begin
            m_pop = 1'b1;
            pops++;
            if (wordq.size() == 0) check("spurious_word", m_valid, 0);
            else check("word_order", m_data, wordq.pop_front());
         end
         if (s_valid && s_ready) begin
            s_acc = 1'b1;
            nibq.push_back(s_data);
            if (nibq.size() == 4) begin
               wordq.push_back({nibq[3], nibq[2], nibq[1], nibq[0]});
               nibq.delete();
            end
         end
         stall_prev = m_valid && !m_ready;
         held       = m_data;
      end
      rst_seen = !rst_n;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n, sent, lat, p0;
      logic        enb1;
      logic [15:0] first;
      logic [3:0]  abcd [4];
      abcd = '{4'hA, 4'hB, 4'hC, 4'hD};

      // Reset held 3 cycles with S_VALID high.
      rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 4'h5; m_ready = 1'b0;
      repeat (3) cyc();
      check("tie_offs", {ssra, web, ssrb, dipb, dib}, '0);

      // Order and latency: nibbles 1..4.
      rst_n = 1'b1;
      for (int unsigned i = 1; i <= 4; i++) begin
         s_data = 4'(i);
         cyc();
         check("lat_accept", s_acc, 1);
      end
      s_valid = 1'b0; m_ready = 1'b1; lat = 0; enb1 = 1'b0; first = '0;
      for (int unsigned k = 1; k <= 8; k++) begin
         cyc();
         if (k == 1) enb1 = obs_enb;
         if (obs_mvalid && lat == 0) begin
            lat   = k;
            first = obs_mdata;
         end
      end
      check("lat_enb", enb1, 1);
      check("latency", lat, 3);
      check("order_4321", first, 16'h4321);

      // Full: capacity is the 4096-nibble RAM plus two words prefetched into the output buffer.
      m_ready = 1'b0; s_valid = 1'b1; n = 0;
      for (int unsigned c = 0; c < 5000; c++) begin
         s_data = 4'($urandom);
         cyc();
         if (s_acc) n++;
         else break;
      end
      check("full_count", n, 4104);
      for (int unsigned c = 0; c < 3; c++) begin
         cyc();
         check("full_hold", obs_sready, 0);
      end
      m_ready = 1'b1;
      cyc();
      check("full_pop", m_pop, 1);
      m_ready = 1'b0; n = 0;
      for (int unsigned c = 0; c < 20; c++) begin
         s_data = 4'($urandom);
         cyc();
         if (s_acc) n++;
      end
      check("refill_count", n, 4);
      check("refill_full", obs_sready, 0);

      // Drain everything.
      s_valid = 1'b0; m_ready = 1'b1;
      for (int unsigned c = 0; c < 3000; c++) begin
         cyc();
         if (wordq.size() == 0 && !obs_mvalid) break;
      end
      check("drain_empty", wordq.size(), 0);
      check("drain_idle", obs_mvalid, 0);

      // Three RAM passes of a ramp with random backpressure on both sides.
      pops = 0; sent = 0;
      for (int unsigned c = 0; c < 40000; c++) begin
         s_valid = (sent < 12288) && ($urandom_range(3) != 0);
         s_data  = 4'(sent);
         m_ready = 1'($urandom_range(1));
         cyc();
         if (s_acc) sent++;
         if (pops == 3072) break;
      end
      check("wrap_sent", sent, 12288);
      check("wrap_words", pops, 3072);

      // Partial word then flush.
      s_valid = 1'b1; m_ready = 1'b1; n = 0;
      for (int unsigned c = 0; c < 20; c++) begin
         s_data = 4'($urandom);
         cyc();
         if (s_acc) n++;
         if (n == 6) break;
      end
      check("partial_sent", n, 6);
      s_valid = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      for (int unsigned c = 0; c < 8; c++) begin
         cyc();
         check("flush_mvalid", obs_mvalid, 0);
      end
      s_valid = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         s_data = abcd[i];
         cyc();
         check("abcd_accept", s_acc, 1);
      end
      s_valid = 1'b0; lat = 0; first = '0;
      for (int unsigned k = 1; k <= 10; k++) begin
         cyc();
         if (obs_mvalid) begin
            lat   = k;
            first = obs_mdata;
            break;
         end
      end
      check("flush_latency", lat, 3);
      check("flush_word", first, 16'hDCBA);

      // Mid-operation reset with the output buffer full.
      m_ready = 1'b0; s_valid = 1'b1; n = 0;
      for (int unsigned c = 0; c < 40; c++) begin
         s_data = 4'($urandom);
         cyc();
         if (s_acc) n++;
         if (n == 12) break;
      end
      s_valid = 1'b0;
      cyc();
      check("midop_buffered", obs_mvalid, 1);
      rst_n = 1'b0; s_valid = 1'b1;
      cyc();
      rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
      for (int unsigned c = 0; c < 6; c++) begin
         cyc();
         check("midop_mvalid", obs_mvalid, 0);
      end
      p0 = pops; s_valid = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         s_data = 4'($urandom);
         cyc();
      end
      s_valid = 1'b0;
      for (int unsigned c = 0; c < 10; c++) cyc();
      check("midop_words", pops - p0, 1);
      check("midop_left", wordq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
